// File: rtl/vga_pkg.sv
// Shared widths, screen geometry and the {x, y} coordinate packing used by the
// VGA pixel arbiter and its requesters.
package vga_pkg;

    localparam int X_W      = 8;
    localparam int Y_W      = 7;
    localparam int COORD_W  = 15;
    localparam int COLOUR_W = 9;
    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;

    typedef enum logic {
        ST_ARB   = 1'b0,
        ST_CLEAR = 1'b1
    } arb_state_e;

    // A coordinate word is {x, y}: x in the upper X_W bits, y in the lower Y_W bits.
    function automatic logic [COORD_W-1:0] pack_coord(input logic [X_W-1:0] x,
                                                      input logic [Y_W-1:0] y);
        return {x, y};
    endfunction

    function automatic logic [X_W-1:0] coord_x(input logic [COORD_W-1:0] c);
        return c[COORD_W-1 -: X_W];
    endfunction

    function automatic logic [Y_W-1:0] coord_y(input logic [COORD_W-1:0] c);
        return c[Y_W-1:0];
    endfunction

endpackage

// File: rtl/pixel_grant_logic.sv
// Combinational one-hot grant for the pixel arbiter: fixed lowest-index
// priority, or a round-robin search starting at ptr_i when RR_EN is set.
module pixel_grant_logic
    import vga_pkg::*;
#(
    parameter int NUM_PORTS = 3,
    parameter int PTR_W     = 2,
    parameter bit RR_EN     = 1'b0
) (
    input  logic [NUM_PORTS-1:0] valid_i,
    input  logic [PTR_W-1:0]     ptr_i,
    input  logic                 en_i,
    output logic [NUM_PORTS-1:0] grant_o,
    output logic [PTR_W-1:0]     grant_idx_o
);

    logic [NUM_PORTS-1:0] grant_fixed;
    logic [NUM_PORTS-1:0] grant_rr;
    logic [PTR_W-1:0]     idx_fixed;
    logic [PTR_W-1:0]     idx_rr;
    logic [PTR_W:0]       rr_sum;
    logic [PTR_W-1:0]     rr_idx;

    // Scanning from the far end lets the nearest candidate overwrite the rest.
    always_comb begin
        grant_fixed = '0;
        idx_fixed   = '0;
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            if (valid_i[i]) begin
                grant_fixed    = '0;
                grant_fixed[i] = 1'b1;
                idx_fixed      = PTR_W'(i);
            end
        end
    end

    always_comb begin
        grant_rr = '0;
        idx_rr   = '0;
        rr_sum   = '0;
        rr_idx   = '0;
        for (int k = NUM_PORTS - 1; k >= 0; k--) begin
            rr_sum = {1'b0, ptr_i} + (PTR_W+1)'(k);
            if (rr_sum >= (PTR_W+1)'(NUM_PORTS)) begin
                rr_sum = rr_sum - (PTR_W+1)'(NUM_PORTS);
            end
            rr_idx = rr_sum[PTR_W-1:0];
            if (valid_i[rr_idx]) begin
                grant_rr         = '0;
                grant_rr[rr_idx] = 1'b1;
                idx_rr           = rr_idx;
            end
        end
    end

    assign grant_o     = !en_i ? '0 : (RR_EN ? grant_rr : grant_fixed);
    assign grant_idx_o = RR_EN ? idx_rr : idx_fixed;

endmodule

// File: rtl/vga_pixel_arbiter.sv
// Merges NUM_PORTS pixel streams into one registered VGA write port, with
// off-screen clipping and a full-screen clear. Define VGA_PIXEL_ARB_RR_EN for round-robin.
module vga_pixel_arbiter
    import vga_pkg::*;
#(
    parameter int NUM_PORTS = 3,
    parameter int SCREEN_W  = vga_pkg::SCREEN_W,
    parameter int SCREEN_H  = vga_pkg::SCREEN_H
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic [NUM_PORTS-1:0]          req_valid,
    input  logic [NUM_PORTS*COORD_W-1:0]  req_coord,
    input  logic [NUM_PORTS*COLOUR_W-1:0] req_colour,
    output logic [NUM_PORTS-1:0]          req_ready,
    input  logic                          clear_start,
    input  logic [COLOUR_W-1:0]           clear_colour,
    output logic                          clear_done,
    output logic [X_W-1:0]                vga_x,
    output logic [Y_W-1:0]                vga_y,
    output logic [COLOUR_W-1:0]           vga_colour,
    output logic                          vga_plot,
    output logic [15:0]                   clip_count,
    output logic                          busy
);

    localparam int PTR_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam logic [X_W-1:0] X_LAST = X_W'(SCREEN_W - 1);
    localparam logic [Y_W-1:0] Y_LAST = Y_W'(SCREEN_H - 1);

    arb_state_e           state_q, state_d;
    logic [X_W-1:0]       cx_q, cx_d;
    logic [Y_W-1:0]       cy_q, cy_d;
    logic [COLOUR_W-1:0]  clr_colour_q, clr_colour_d;
    logic [X_W-1:0]       vga_x_q, vga_x_d;
    logic [Y_W-1:0]       vga_y_q, vga_y_d;
    logic [COLOUR_W-1:0]  vga_colour_q, vga_colour_d;
    logic                 vga_plot_q, vga_plot_d;
    logic                 clear_done_q, clear_done_d;
    logic [15:0]          clip_count_q, clip_count_d;

    logic                 grant_en;
    logic                 transfer;
    logic [PTR_W-1:0]     grant_idx;
    logic [PTR_W-1:0]     ptr;
    logic [COORD_W-1:0]   sel_coord;
    logic [COLOUR_W-1:0]  sel_colour;
    logic [X_W-1:0]       sel_x;
    logic [Y_W-1:0]       sel_y;
    logic                 sel_onscreen;

`ifdef VGA_PIXEL_ARB_RR_EN
    localparam bit RR_EN = 1'b1;
    logic [PTR_W-1:0] ptr_q, ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (transfer) begin
            ptr_d = (grant_idx == PTR_W'(NUM_PORTS - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) ptr_q <= '0;
        else         ptr_q <= ptr_d;
    end

    assign ptr = ptr_q;
`else
    localparam bit RR_EN = 1'b0;
    assign ptr = '0;
`endif

    // A clear request in ARB takes the cycle, so nobody is granted alongside it.
    assign grant_en = (state_q == ST_ARB) && !clear_start;
    assign transfer = |req_ready;

    pixel_grant_logic #(
        .NUM_PORTS (NUM_PORTS),
        .PTR_W     (PTR_W),
        .RR_EN     (RR_EN)
    ) u_grant (
        .valid_i     (req_valid),
        .ptr_i       (ptr),
        .en_i        (grant_en),
        .grant_o     (req_ready),
        .grant_idx_o (grant_idx)
    );

    assign sel_coord    = req_coord[grant_idx*COORD_W +: COORD_W];
    assign sel_colour   = req_colour[grant_idx*COLOUR_W +: COLOUR_W];
    assign sel_x        = coord_x(sel_coord);
    assign sel_y        = coord_y(sel_coord);
    assign sel_onscreen = (sel_x <= X_LAST) && (sel_y <= Y_LAST);

    always_comb begin
        state_d      = state_q;
        cx_d         = cx_q;
        cy_d         = cy_q;
        clr_colour_d = clr_colour_q;
        vga_x_d      = vga_x_q;
        vga_y_d      = vga_y_q;
        vga_colour_d = vga_colour_q;
        vga_plot_d   = 1'b0;
        clear_done_d = 1'b0;
        clip_count_d = clip_count_q;
        unique case (state_q)
            ST_ARB: begin
                if (clear_start) begin
                    state_d      = ST_CLEAR;
                    cx_d         = '0;
                    cy_d         = '0;
                    clr_colour_d = clear_colour;
                end else if (transfer) begin
                    if (sel_onscreen) begin
                        vga_x_d      = sel_x;
                        vga_y_d      = sel_y;
                        vga_colour_d = sel_colour;
                        vga_plot_d   = 1'b1;
                    end else if (clip_count_q != 16'hFFFF) begin
                        clip_count_d = clip_count_q + 16'd1;
                    end
                end
            end
            ST_CLEAR: begin
                vga_x_d      = cx_q;
                vga_y_d      = cy_q;
                vga_colour_d = clr_colour_q;
                vga_plot_d   = 1'b1;
                if (cx_q == X_LAST) begin
                    cx_d = '0;
                    if (cy_q == Y_LAST) begin
                        cy_d         = '0;
                        state_d      = ST_ARB;
                        clear_done_d = 1'b1;
                    end else begin
                        cy_d = cy_q + 1'b1;
                    end
                end else begin
                    cx_d = cx_q + 1'b1;
                end
            end
            default: state_d = ST_ARB;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q      <= ST_ARB;
            cx_q         <= '0;
            cy_q         <= '0;
            clr_colour_q <= '0;
            vga_x_q      <= '0;
            vga_y_q      <= '0;
            vga_colour_q <= '0;
            vga_plot_q   <= 1'b0;
            clear_done_q <= 1'b0;
            clip_count_q <= '0;
        end else begin
            state_q      <= state_d;
            cx_q         <= cx_d;
            cy_q         <= cy_d;
            clr_colour_q <= clr_colour_d;
            vga_x_q      <= vga_x_d;
            vga_y_q      <= vga_y_d;
            vga_colour_q <= vga_colour_d;
            vga_plot_q   <= vga_plot_d;
            clear_done_q <= clear_done_d;
            clip_count_q <= clip_count_d;
        end
    end

    assign vga_x      = vga_x_q;
    assign vga_y      = vga_y_q;
    assign vga_colour = vga_colour_q;
    assign vga_plot   = vga_plot_q;
    assign clear_done = clear_done_q;
    assign clip_count = clip_count_q;
    assign busy       = (state_q == ST_CLEAR);

endmodule

// File: tb/tb_vga_pixel_arbiter.sv
// Directed bench for vga_pixel_arbiter: a pixel-index model of the arbiter runs
// alongside the DUT and is checked every cycle, plus literal spot checks.
module tb_vga_pixel_arbiter;
  import vga_pkg::*;

  localparam int NP = 3;
  localparam int W  = 160;
  localparam int H  = 120;

  // valid/ready: a pixel moves when req_valid[i] & req_ready[i] are both high
  // in a cycle; requesters hold coord/colour steady until that happens.

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  logic [NP-1:0]    req_valid = '0;
  logic [NP*15-1:0] req_coord = '0;
  logic [NP*9-1:0]  req_colour = '0;
  logic [NP-1:0]    req_ready;
  logic             clear_start = 1'b0;
  logic [8:0]       clear_colour = '0;
  logic             clear_done;
  logic [7:0]       vga_x;
  logic [6:0]       vga_y;
  logic [8:0]       vga_colour;
  logic             vga_plot;
  logic [15:0]      clip_count;
  logic             busy;

  vga_pixel_arbiter #(.NUM_PORTS(NP), .SCREEN_W(W), .SCREEN_H(H)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .req_valid    (req_valid),
    .req_coord    (req_coord),
    .req_colour   (req_colour),
    .req_ready    (req_ready),
    .clear_start  (clear_start),
    .clear_colour (clear_colour),
    .clear_done   (clear_done),
    .vga_x        (vga_x),
    .vga_y        (vga_y),
    .vga_colour   (vga_colour),
    .vga_plot     (vga_plot),
    .clip_count   (clip_count),
    .busy         (busy)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit          m_ok = 0;
  bit          m_clear = 0;
  int          m_n = 0;
  logic [8:0]  m_clr_col = '0;
  logic [7:0]  m_x = '0;
  logic [6:0]  m_y = '0;
  logic [8:0]  m_c = '0;
  bit          m_known = 1;
  logic        m_done = 0;
  logic [15:0] m_clip = '0;
  int          m_ptr = 0;
  logic [23:0] exp_q[$];

  function automatic int model_pick(input logic [NP-1:0] v);
    int start;
    int p;
`ifdef VGA_PIXEL_ARB_RR_EN
    start = m_ptr;
`else
    start = 0;
`endif
    for (int k = 0; k < NP; k++) begin
      p = (start + k) % NP;
      if (v[p]) return p;
    end
    return -1;
  endfunction

  task automatic model_step();
    int g;
    logic [14:0] cd;
    logic [7:0] gx;
    logic [6:0] gy;
    logic [8:0] gc;
    if (!resetn) begin
      m_ok = 1; m_clear = 0; m_n = 0; m_clr_col = '0;
      m_x = '0; m_y = '0; m_c = '0; m_known = 1;
      m_done = 0; m_clip = '0; m_ptr = 0;
      exp_q.delete();
      return;
    end
    if (!m_ok) return;
    m_done = 0;
    if (m_clear) begin
      m_x = 8'(m_n % W);
      m_y = 7'(m_n / W);
      m_c = m_clr_col;
      m_known = 1;
      exp_q.push_back({m_x, m_y, m_c});
      m_n++;
      if (m_n == W * H) begin
        m_clear = 0;
        m_done = 1;
      end
    end else if (clear_start) begin
      m_clear = 1;
      m_n = 0;
      m_clr_col = clear_colour;
    end else begin
      g = model_pick(req_valid);
      if (g >= 0) begin
        cd = req_coord[15*g +: 15];
        gx = cd[14:7];
        gy = cd[6:0];
        gc = req_colour[9*g +: 9];
        if (gx < W && gy < H) begin
          m_x = gx; m_y = gy; m_c = gc; m_known = 1;
          exp_q.push_back({gx, gy, gc});
        end else begin
          if (m_clip != 16'hFFFF) m_clip++;
          m_known = 0;
        end
        m_ptr = (g + 1) % NP;
      end
    end
  endtask

  task automatic compare_step();
    int g;
    logic [NP-1:0] exp_rdy;
    logic [23:0] e;
    g = (m_clear || clear_start) ? -1 : model_pick(req_valid);
    exp_rdy = (g < 0) ? '0 : NP'(1 << g);
    check("req_ready", 32'(req_ready), 32'(exp_rdy));
    check("busy", 32'(busy), 32'(m_clear));
    check("clear_done", 32'(clear_done), 32'(m_done));
    check("clip_count", 32'(clip_count), 32'(m_clip));
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check("vga_plot", 32'(vga_plot), 32'd1);
      check("pixel", 32'({vga_x, vga_y, vga_colour}), 32'(e));
    end else begin
      check("vga_plot", 32'(vga_plot), 32'd0);
      if (m_known) check("pixel_hold", 32'({vga_x, vga_y, vga_colour}), 32'({m_x, m_y, m_c}));
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (m_ok) compare_step();
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_port(input int p, input logic [7:0] x, input logic [6:0] y,
                          input logic [8:0] c);
    req_coord[15*p +: 15] = pack_coord(x, y);
    req_colour[9*p +: 9] = c;
  endtask

  task automatic finish_run();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  endtask

  initial begin
    #(1500000 * 10);
    n_err++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $fatal(1, "watchdog");
  end

  // ---------------- directed tests ----------------
  initial begin
    int c0, c2, nplot, nready, ndone, iter;
    bit done_seen;

    repeat (3) step();
    resetn = 1'b1;
    @(negedge clk);
    check("reset_plot", 32'(vga_plot), 32'd0);
    check("reset_xy", 32'({vga_x, vga_y, vga_colour}), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_clip", 32'(clip_count), 32'd0);

    // single pixel from the tower placer
    step();
    set_port(0, 8'd20, 7'd40, 9'h1C0);
    req_valid = 3'b001;
    @(negedge clk);
    check("t1_ready", 32'(req_ready), 32'b001);
    step();
    req_valid = '0;
    @(negedge clk);
    check("t1_plot", 32'(vga_plot), 32'd1);
    check("t1_x", 32'(vga_x), 32'd20);
    check("t1_y", 32'(vga_y), 32'd40);
    check("t1_colour", 32'(vga_colour), 32'h1C0);

    // contention between ports 0 and 2
    step();
    set_port(0, 8'd10, 7'd10, 9'h011);
    set_port(2, 8'd30, 7'd30, 9'h022);
    req_valid = 3'b101;
    c0 = 0; c2 = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (req_ready[0]) c0++;
      if (req_ready[2]) c2++;
      step();
    end
    req_valid = '0;
`ifdef VGA_PIXEL_ARB_RR_EN
    check("t2_port0_grants", 32'(c0), 32'd4);
    check("t2_port2_grants", 32'(c2), 32'd4);
`else
    check("t2_port0_grants", 32'(c0), 32'd8);
    check("t2_port2_grants", 32'(c2), 32'd0);
`endif

    // clipping on both axes
    step();
    set_port(1, 8'd160, 7'd5, 9'h0F0);
    req_valid = 3'b010;
    @(negedge clk);
    check("t3_ready_a", 32'(req_ready), 32'b010);
    step();
    set_port(1, 8'd3, 7'd120, 9'h0F0);
    @(negedge clk);
    check("t3_ready_b", 32'(req_ready), 32'b010);
    check("t3_plot_a", 32'(vga_plot), 32'd0);
    step();
    req_valid = '0;
    @(negedge clk);
    check("t3_plot_b", 32'(vga_plot), 32'd0);
    check("t3_clip_count", 32'(clip_count), 32'd2);

    // full clear against a waiting requester, with a stray clear_start
    step();
    set_port(0, 8'd1, 7'd2, 9'h155);
    req_valid = 3'b001;
    clear_colour = 9'h000;
    clear_start = 1'b1;
    @(negedge clk);
    check("t4_ready_at_start", 32'(req_ready), 32'd0);
    nplot = 0; nready = 0; ndone = 0; iter = 0; done_seen = 0;
    while (!done_seen && iter < 20000) begin
      step();
      clear_start = (iter == 100);
      clear_colour = (iter == 100) ? 9'h1FF : 9'h000;
      @(negedge clk);
      if (vga_plot) nplot++;
      if (|req_ready) nready++;
      if (clear_done) begin
        ndone++;
        done_seen = 1;
        check("t4_last_x", 32'(vga_x), 32'd159);
        check("t4_last_y", 32'(vga_y), 32'd119);
        check("t4_last_plot", 32'(vga_plot), 32'd1);
        check("t4_ready_after", 32'(req_ready), 32'b001);
      end
      iter++;
    end
    clear_start = 1'b0;
    check("t4_done_seen", 32'(done_seen), 32'd1);
    check("t4_plots", 32'(nplot), 32'd19200);
    check("t4_ready_cycles", 32'(nready), 32'd1);
    check("t4_done_count", 32'(ndone), 32'd1);
    step();
    req_valid = '0;
    @(negedge clk);
    check("t4_req_plot", 32'(vga_plot), 32'd1);
    check("t4_req_x", 32'(vga_x), 32'd1);
    check("t4_done_pulse", 32'(clear_done), 32'd0);
    repeat (3) step();
    @(negedge clk);
    check("t4_no_requeue", 32'(busy), 32'd0);

    // reset in the middle of a clear
    step();
    clear_colour = 9'h1FF;
    clear_start = 1'b1;
    step();
    clear_start = 1'b0;
    ndone = 0;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      if (clear_done) ndone++;
      step();
    end
    resetn = 1'b0;
    step();
    resetn = 1'b1;
    @(negedge clk);
    check("t5_no_done", 32'(ndone + int'(clear_done)), 32'd0);
    check("t5_plot", 32'(vga_plot), 32'd0);
    check("t5_xyc", 32'({vga_x, vga_y, vga_colour}), 32'd0);
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_clip", 32'(clip_count), 32'd0);
    step();
    set_port(2, 8'd7, 7'd9, 9'h0AA);
    req_valid = 3'b100;
    @(negedge clk);
    check("t5_ready", 32'(req_ready), 32'b100);
    step();
    req_valid = '0;
    @(negedge clk);
    check("t5_pixel", 32'({vga_plot, vga_x, vga_y, vga_colour}),
          32'({1'b1, 8'd7, 7'd9, 9'h0AA}));

    // clip counter saturation
    step();
    set_port(0, 8'd200, 7'd0, 9'h003);
    req_valid = 3'b001;
    repeat (65540) step();
    req_valid = '0;
    @(negedge clk);
    check("t6_clip_sat", 32'(clip_count), 32'hFFFF);
    check("t6_plot", 32'(vga_plot), 32'd0);

    step();
    @(negedge clk);
    finish_run();
  end

endmodule
